// File: rtl/mgmt_bus_pkg.sv
// mgmt_bus_pkg: shared request types, read FSM encoding and helpers for the management bus fabric.
package mgmt_bus_pkg;
    localparam int MB_ADDR_WIDTH = 16;
    localparam int MB_DATA_WIDTH = 8;
    localparam logic [MB_DATA_WIDTH-1:0] MB_ERR_DATA = 8'hEE;

    localparam logic [1:0] MB_IDLE = 2'd0;
    localparam logic [1:0] MB_WAIT = 2'd1;
    localparam logic [1:0] MB_RESP = 2'd2;

    typedef struct packed {
        logic                     en;
        logic [MB_ADDR_WIDTH-1:0] addr;
    } mgmt_rd_req_t;

    typedef struct packed {
        logic                     en;
        logic [MB_ADDR_WIDTH-1:0] addr;
        logic [MB_DATA_WIDTH-1:0] data;
    } mgmt_wr_req_t;

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
endpackage

// File: rtl/mgmt_bus_if.sv
// mgmt_bus_if: host-side read/write bus between the QSPI management bridge and the fabric.
interface mgmt_bus_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data,
        input  rd_valid, rd_data
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data,
        output rd_valid, rd_data
    );
endinterface

// File: rtl/mgmt_bus_pipe.sv
// mgmt_bus_pipe: resettable DEPTH-stage delay line for request structs.
module mgmt_bus_pipe #(
    parameter int  DEPTH = 1,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst_n,
    input  T     d,
    output T     q
);
    T stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/mgmt_bus_fabric.sv
// mgmt_bus_fabric: pipelined address-window decoder with read timeout and error reporting
// between the management bridge and NUM_PERIPH register-space peripherals.
module mgmt_bus_fabric
    import mgmt_bus_pkg::*;
#(
    parameter int NUM_PERIPH     = 4,
    parameter int ADDR_WIDTH     = MB_ADDR_WIDTH,
    parameter int DATA_WIDTH     = MB_DATA_WIDTH,
    parameter int WIN_BITS       = 12,
    parameter int PIPE_STAGES    = 0,
    parameter int TIMEOUT_CYCLES = 255,
    parameter logic [DATA_WIDTH-1:0] ERR_DATA = MB_ERR_DATA
) (
    input  logic                           clk,
    input  logic                           rst_n,
    mgmt_bus_if.slave                      host,
    output logic [NUM_PERIPH-1:0]          p_rd_en,
    output logic [WIN_BITS-1:0]            p_rd_addr,
    input  logic [NUM_PERIPH-1:0]          p_rd_valid,
    input  logic [NUM_PERIPH*DATA_WIDTH-1:0] p_rd_data,
    output logic [NUM_PERIPH-1:0]          p_wr_en,
    output logic [WIN_BITS-1:0]            p_wr_addr,
    output logic [DATA_WIDTH-1:0]          p_wr_data,
    output logic                           busy,
    input  logic                           err_clr,
    output logic [15:0]                    err_timeout_cnt,
    output logic [15:0]                    err_unmapped_cnt,
    output logic                           err_overlap
);
    localparam int IW = ADDR_WIDTH - WIN_BITS;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    mgmt_rd_req_t rd_d, rd_q;
    mgmt_wr_req_t wr_d, wr_q;

    assign rd_d = '{en: host.rd_en, addr: host.rd_addr};
    assign wr_d = '{en: host.wr_en, addr: host.wr_addr, data: host.wr_data};

    mgmt_bus_pipe #(.DEPTH(1 + PIPE_STAGES), .T(mgmt_rd_req_t)) u_rd_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rd_d),
        .q     (rd_q)
    );

    mgmt_bus_pipe #(.DEPTH(1 + PIPE_STAGES), .T(mgmt_wr_req_t)) u_wr_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (wr_d),
        .q     (wr_q)
    );

    logic [1:0]            state;
    logic [TW-1:0]         timer;
    logic [NUM_PERIPH-1:0] sel_oh, rd_oh, wr_oh, cur_oh;
    logic [IW-1:0]         rd_idx, wr_idx;
    logic [DATA_WIDTH-1:0] hit_data, rd_data_q;
    logic                  rd_valid_q, rd_go, rd_unmap, wr_unmap, hit, tmo, overlap;

    assign rd_idx = rd_q.addr[ADDR_WIDTH-1:WIN_BITS];
    assign wr_idx = wr_q.addr[ADDR_WIDTH-1:WIN_BITS];

    always_comb begin
        rd_oh = '0;
        wr_oh = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            rd_oh[i] = rd_q.en && 32'(rd_idx) == i;
            wr_oh[i] = wr_q.en && 32'(wr_idx) == i;
        end
    end

    assign rd_go    = rd_q.en && state == MB_IDLE;
    assign rd_unmap = rd_go && !(|rd_oh);
    assign wr_unmap = wr_q.en && !(|wr_oh);
    assign overlap  = rd_q.en && state != MB_IDLE;

    // In IDLE the freshly decoded read is the selection, so an L=0 response is caught
    assign cur_oh = state == MB_IDLE ? rd_oh : sel_oh;
    assign hit    = |(p_rd_valid & cur_oh);
    assign tmo    = state == MB_WAIT && timer == TW'(TIMEOUT_CYCLES - 1) && !hit;

    always_comb begin
        hit_data = '0;
        for (int i = 0; i < NUM_PERIPH; i++)
            hit_data = hit_data | (cur_oh[i] ? p_rd_data[i*DATA_WIDTH +: DATA_WIDTH] : '0);
    end

    assign p_rd_en   = rd_go ? rd_oh : '0;
    assign p_rd_addr = rd_q.addr[WIN_BITS-1:0];
    assign p_wr_en   = wr_oh;
    assign p_wr_addr = wr_q.addr[WIN_BITS-1:0];
    assign p_wr_data = wr_q.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MB_IDLE;
            timer      <= '0;
            sel_oh     <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= 1'b0;
            if (rd_go) begin
                sel_oh <= rd_oh;
                timer  <= '0;
                if (rd_unmap || hit) begin
                    state      <= MB_RESP;
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= rd_unmap ? ERR_DATA : hit_data;
                end else begin
                    state <= MB_WAIT;
                end
            end else if (state == MB_WAIT) begin
                timer <= timer + 1'b1;
                if (hit || tmo) begin
                    state      <= MB_RESP;
                    rd_valid_q <= 1'b1;
                    rd_data_q  <= hit ? hit_data : ERR_DATA;
                end
            end else begin
                state <= MB_IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout_cnt  <= '0;
            err_unmapped_cnt <= '0;
            err_overlap      <= 1'b0;
        end else if (err_clr) begin
            err_timeout_cnt  <= '0;
            err_unmapped_cnt <= '0;
            err_overlap      <= 1'b0;
        end else begin
            err_timeout_cnt  <= sat_add(err_timeout_cnt, {1'b0, tmo});
            err_unmapped_cnt <= sat_add(err_unmapped_cnt, {1'b0, rd_unmap} + {1'b0, wr_unmap});
            err_overlap      <= err_overlap | overlap;
        end
    end

    assign busy          = state != MB_IDLE;
    assign host.rd_valid = rd_valid_q;
    assign host.rd_data  = rd_data_q;
endmodule
